// File: rtl/calc_pkg.sv
// Shared definitions for the calculator: operation codes, FSM state encodings
// and the default operand width.
package calc_pkg;

  localparam int unsigned CALC_WIDTH = 16;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  typedef enum logic [2:0] {
    StGetA  = 3'd0,
    StGetB  = 3'd1,
    StGetOp = 3'd2,
    StExec  = 3'd3,
    StShow  = 3'd4
  } state_e;

endpackage

// File: rtl/calc_iter_unit.sv
// Iterative unsigned multiplier (shift-add) and restoring divider, one bit per
// cycle. result/hi_nonzero show the value the current step produces, so on the
// WIDTH-th cycle after start they carry the final answer ahead of the clock
// edge and the caller can register it on that same edge.
module calc_iter_unit
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             hi_nonzero
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               is_div_q;
  logic [CntW-1:0]    cnt_q;
  logic [2*WIDTH-1:0] mcand_q, prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q;
  logic [WIDTH-1:0]   rem_q, quo_q, div_q, rem_d, quo_d;
  logic [WIDTH:0]     shifted, trial;

  // One multiply step and one restoring-divide step from the current copies.
  always_comb begin
    prod_d  = prod_q + (mplier_q[0] ? mcand_q : '0);
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, div_q};
    // trial[WIDTH] set means the trial subtraction went negative: restore.
    rem_d   = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d   = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  // Outputs reflect the step in progress.
  always_comb begin
    result     = is_div_q ? quo_d : prod_d[WIDTH-1:0];
    hi_nonzero = !is_div_q && (prod_d[2*WIDTH-1:WIDTH] != '0);
  end

  // Load operand copies on start, then iterate for WIDTH cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_div_q <= 1'b0;
      cnt_q    <= '0;
      busy     <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
    end else if (start) begin
      is_div_q <= (op == OP_DIV);
      cnt_q    <= '0;
      busy     <= 1'b1;
      mcand_q  <= {{WIDTH{1'b0}}, a};
      prod_q   <= '0;
      mplier_q <= b;
      rem_q    <= '0;
      quo_q    <= a;
      div_q    <= b;
    end else if (busy) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= prod_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_q + 1'b1;
      if (cnt_q == CntW'(WIDTH - 1)) begin
        busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// Four-function calculator sequencer: collects A, B and an operation from the
// switches on enter pulses, computes C (ADD/SUB in one cycle, MUL/DIV over
// WIDTH cycles), shows the result and allows chaining it into the next op.
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = CALC_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             enter,
  input  logic             clear,
  input  logic [1:0]       op_sel,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] C,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic             dz
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [CntW-1:0]  exec_cnt;
  logic [WIDTH:0]   sum;
  logic             iter_start, iter_busy, iter_hi_nonzero;
  logic [WIDTH-1:0] iter_result;

  assign state = state_q;

  // Carry-extended sum for ADD.
  always_comb begin
    sum = {1'b0, A} + {1'b0, B};
  end

  // The iterative unit loads its copies on the same edge that enters EXEC.
  always_comb begin
    iter_start = (state_q == StGetOp) && enter && !clear && op_sel[1];
  end

  calc_iter_unit #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk       (clk),
    .rst       (rst),
    .start     (iter_start),
    .op        (op_sel),
    .a         (A),
    .b         (B),
    .busy      (iter_busy),
    .result    (iter_result),
    .hi_nonzero(iter_hi_nonzero)
  );

  // Main FSM with registered outputs; clear overrides everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StGetA;
      op_q     <= OP_ADD;
      exec_cnt <= '0;
      A        <= '0;
      B        <= '0;
      C        <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ovf      <= 1'b0;
      dz       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (clear) begin
        state_q  <= StGetA;
        exec_cnt <= '0;
        A        <= '0;
        B        <= '0;
        C        <= '0;
        busy     <= 1'b0;
        ovf      <= 1'b0;
        dz       <= 1'b0;
      end else begin
        unique case (state_q)
          StGetA: begin
            if (enter) begin
              A       <= sw;
              state_q <= StGetB;
            end
          end
          StGetB: begin
            if (enter) begin
              B       <= sw;
              state_q <= StGetOp;
            end
          end
          StGetOp: begin
            if (enter) begin
              op_q     <= op_sel;
              ovf      <= 1'b0;
              dz       <= 1'b0;
              exec_cnt <= '0;
              busy     <= 1'b1;
              state_q  <= StExec;
            end
          end
          StExec: begin
            unique case (op_q)
              OP_ADD: begin
                C       <= sum[WIDTH-1:0];
                ovf     <= sum[WIDTH];
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= StShow;
              end
              OP_SUB: begin
                C       <= A - B;
                ovf     <= (A < B);
                busy    <= 1'b0;
                done    <= 1'b1;
                state_q <= StShow;
              end
              default: begin
                if (op_q == OP_DIV && B == '0) begin
                  C       <= '1;
                  dz      <= 1'b1;
                  ovf     <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StShow;
                end else if (iter_busy && exec_cnt == CntW'(WIDTH - 1)) begin
                  C       <= iter_result;
                  ovf     <= iter_hi_nonzero;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_q <= StShow;
                end else begin
                  exec_cnt <= exec_cnt + 1'b1;
                end
              end
            endcase
          end
          StShow: begin
            if (enter) begin
              A       <= C;
              B       <= '0;
              C       <= '0;
              state_q <= StGetB;
            end
          end
          default: state_q <= StGetA;
        endcase
      end
    end
  end

endmodule

// File: doc/calc_sequencer.md
CALC_SEQUENCER -- requirements
Module: calc_sequencer

Interface
REQ-001 Parameter: WIDTH, default 16, operand/result width in bits.
REQ-002 clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 sw  input  WIDTH  operand value from the board switches.
REQ-005 enter  input  1  single-cycle pulse, already debounced upstream.
REQ-006 clear  input  1  single-cycle pulse, already debounced upstream.
REQ-007 op_sel  input  2  operation code: 0 ADD, 1 SUB, 2 MUL, 3 DIV.
REQ-008 A, B, C  output  WIDTH each  registered operand A, operand B and result, feeding the display block.
REQ-009 state  output  3  current state encoding, driven for the display and LEDs.
REQ-010 busy  output  1  high while in EXEC.
REQ-011 done  output  1  one-cycle pulse when C is written.
REQ-012 ovf  output  1  sticky flag: the last result overflowed.
REQ-013 dz  output  1  sticky flag: the last DIV had a zero divisor.

Function
REQ-014 FSM states: GET_A, GET_B, GET_OP, EXEC, SHOW.
REQ-015 GET_A: on enter, A<=sw and the FSM goes to GET_B.
REQ-016 GET_B: on enter, B<=sw and the FSM goes to GET_OP.
REQ-017 GET_OP: on enter, op_sel is latched internally, ovf and dz are cleared, and the FSM goes to EXEC.
REQ-018 EXEC timing for ADD/SUB: C is written on the first EXEC edge.
REQ-019 EXEC timing for MUL/DIV: C is written on the WIDTH-th EXEC edge; the unit is an iterative shift-add multiplier or restoring divider, one bit per cycle.
REQ-020 DIV with B==0: C<=all-ones and dz<=1 on the first EXEC edge; no iteration is performed.
REQ-021 Transition out of EXEC: on the edge that writes C, the FSM goes to SHOW and done is 1 for exactly the following cycle.
REQ-022 ADD: C=(A+B) mod 2^WIDTH; ovf=carry-out.
REQ-023 SUB: C=(A-B) mod 2^WIDTH; ovf=(A<B).
REQ-024 MUL: C=low WIDTH bits of A*B; ovf=(high WIDTH bits != 0).
REQ-025 DIV: C=floor(A/B); ovf=0. All operands are unsigned.
REQ-026 SHOW, operation chaining: on enter, A<=C, B<=0, C<=0 and the FSM goes to GET_B.
REQ-027 clear: in any state, A, B, C, ovf and dz are set to 0 and the FSM goes to GET_A on the next edge; this aborts an EXEC in progress and no done pulse is produced.
REQ-028 clear and enter in the same cycle: clear wins and enter is discarded.
REQ-029 enter during EXEC is ignored and is not queued.
REQ-030 sw and op_sel are sampled only on an accepted enter; changes during EXEC do not affect the result.
REQ-031 A and B are held stable throughout EXEC; the iterative unit works on internal copies.

Reset
REQ-032 While rst=0: state=GET_A; A=B=C=0; busy=done=ovf=dz=0; iteration counter and internal operand/partial registers=0.
REQ-033 rst asserted mid-EXEC aborts the operation immediately; no done pulse is produced after release.
REQ-034 After rst deasserts, the first accepted enter loads A.

Structure
REQ-035 A shared package calc_pkg holds the op codes (OP_ADD..OP_DIV), the state encodings and the WIDTH default; calculator_output and the top level import it.
REQ-036 One sub-module, calc_iter_unit, implements MUL/DIV. Its interface is start, op, a, b, then busy, result, hi_nonzero; it finishes in exactly WIDTH cycles after start.
REQ-037 The FSM, ADD/SUB logic and flags live in calc_sequencer; every output is registered.

Verification
REQ-038 Basic ADD: enter sw=5, enter sw=7, enter op=ADD -> C=12 one edge after op enter; done pulses once; ovf=0.
REQ-039 ADD overflow: A=16'hFFFF, B=1, ADD -> C=0, ovf=1.
REQ-040 SUB underflow: A=3, B=5, SUB -> C=16'hFFFE, ovf=1.
REQ-041 MUL latency and overflow: A=300, B=300, MUL -> C=16'h5F90 (90000 mod 65536) exactly 16 EXEC edges after op enter; ovf=1; busy high for 16 cycles; enter pulses during EXEC change nothing.
REQ-042 DIV and chaining: A=100, B=7, DIV -> C=14. Then: divide-by-zero case B=0 -> C=16'hFFFF, dz=1 after 1 cycle. Chaining: enter in SHOW after C=14 -> A=14, B=0, state=GET_B.
REQ-043 Abort: clear at EXEC cycle 8 of a MUL -> GET_A, all outputs 0, no done pulse. Repeat with rst=0 mid-EXEC -> same result. Repeat with clear and enter in the same cycle -> clear wins.
